pe_dot_sequencer: RTL and testbench

Job-level controller for one 26-bit carry-save MAC processing element (PE). Per job:
- accepts `cfg_len` (encoder position, operand) pairs over a valid/ready stream;
- drives the PE input ports and its active-low accumulator clear;
- inserts zero-contribution bubbles when the stream stalls;
- after the PE pipeline drains, resolves the redundant sum/carry into one signed dot-product value and returns it through a valid/ready output.

It sits between the operand-fetch/encoder front end and the PE.

---
 rtl/pe_dot_sequencer.sv | 139 +++++++++++++
 tb/tb_pe_dot_sequencer.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_dot_sequencer.sv
// Job-level controller for a carry-save MAC PE: streams operand pairs into the PE,
// aligns its accumulator clear, and returns the resolved signed dot product.
module pe_dot_sequencer #(
  parameter int ACC_WIDTH = 26,
  parameter int LEN_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [LEN_WIDTH-1:0]   cfg_len,
  output logic                   busy,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [1:0]             in_pos,
  input  logic [7:0]             in_b,
  output logic [1:0]             pe_encoder_position,
  output logic [7:0]             pe_operand_b,
  output logic                   pe_clr,
  input  logic [2*ACC_WIDTH-1:0] pe_result,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ACC_WIDTH-1:0]   out_data
);

  // Handshakes: an element transfers on a rising edge where in_valid && in_ready;
  // a result transfers on a rising edge where out_valid && out_ready. Valids hold
  // their payload stable until the transfer.
  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, OUT} state_t;

  localparam logic [LEN_WIDTH-1:0] LEN_ONE = 1;

  state_t               state;
  state_t               state_next;
  logic [LEN_WIDTH-1:0] len_q;
  logic [LEN_WIDTH-1:0] count;
  logic [1:0]           drain_cnt;
  logic                 first_d1;
  logic                 first_d2;
  logic                 accept;
  logic                 last_accept;
  logic                 drain_done;

  assign accept      = (state == STREAM) && in_valid;
  assign last_accept = accept && ((count + LEN_ONE) == len_q);
  assign drain_done  = (state == DRAIN) && (drain_cnt == 2'd2);

  assign busy     = (state != IDLE);
  assign in_ready = (state == STREAM);
  // The PE applies clr to the accumulate that consumes its registered operand,
  // so the first-element tag is delayed one stage past the pe_* registers.
  assign pe_clr   = ~first_d2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = (cfg_len == '0) ? OUT : STREAM;
        end
      end
      STREAM: begin
        if (last_accept) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (drain_done) begin
          state_next = OUT;
        end
      end
      OUT: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pe_encoder_position <= 2'd1;
      pe_operand_b        <= 8'd0;
      first_d1            <= 1'b0;
      first_d2            <= 1'b0;
      len_q               <= '0;
      count               <= '0;
      drain_cnt           <= 2'd0;
      out_valid           <= 1'b0;
      out_data            <= '0;
    end else begin
      // Anything other than an accepted element is a zero-contribution bubble (+1 * 0).
      pe_encoder_position <= accept ? in_pos : 2'd1;
      pe_operand_b        <= accept ? in_b : 8'd0;
      first_d1            <= accept && (count == '0);
      first_d2            <= first_d1;
      case (state)
        IDLE: begin
          if (start) begin
            len_q     <= cfg_len;
            count     <= '0;
            drain_cnt <= 2'd0;
            if (cfg_len == '0) begin
              out_data  <= '0;
              out_valid <= 1'b1;
            end
          end
        end
        STREAM: begin
          if (accept) begin
            count <= count + LEN_ONE;
          end
        end
        DRAIN: begin
          drain_cnt <= drain_cnt + 2'd1;
          if (drain_done) begin
            out_data  <= pe_result[2*ACC_WIDTH-1:ACC_WIDTH] + pe_result[ACC_WIDTH-1:0];
            out_valid <= 1'b1;
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pe_dot_sequencer.sv
// Bench for pe_dot_sequencer: drives directed jobs into the sequencer, models the
// attached carry-save PE, and checks every cycle against a job-level reference model.
module tb_pe_dot_sequencer;

  localparam int ACC_W = 26;
  localparam int LEN_W = 16;

  logic               clk = 1'b0;
  logic               rst_n = 1'b1;
  logic               start = 1'b0;
  logic [LEN_W-1:0]   cfg_len = '0;
  logic               busy;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [1:0]         in_pos = 2'd0;
  logic [7:0]         in_b = 8'h5a;
  logic [1:0]         pe_encoder_position;
  logic [7:0]         pe_operand_b;
  logic               pe_clr;
  logic [2*ACC_W-1:0] pe_result;
  logic               out_valid;
  logic               out_ready = 1'b1;
  logic [ACC_W-1:0]   out_data;

  int n_vec = 0;
  int n_miss = 0;
  int clr_lows = 0;
  logic [ACC_W-1:0] exp_q[$];

  pe_dot_sequencer #(.ACC_WIDTH(ACC_W), .LEN_WIDTH(LEN_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_len(cfg_len), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready), .in_pos(in_pos), .in_b(in_b),
    .pe_encoder_position(pe_encoder_position), .pe_operand_b(pe_operand_b),
    .pe_clr(pe_clr), .pe_result(pe_result), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic do_reset();
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  function automatic logic [ACC_W-1:0] contrib(input logic [1:0] p, input logic [7:0] b);
    int v;
    v = int'($signed(b));
    case (p)
      2'd0:    v = -2 * v;
      2'd1:    v = v;
      2'd2:    v = 2 * v;
      default: v = -v;
    endcase
    return v[ACC_W-1:0];
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, got, got, exp, exp, $time);
    end
  endtask

  // PE model: registers its inputs, clr gates the following accumulate; the
  // redundant split between sum and carry is scrambled every cycle.
  logic [1:0]       pe_op_pos = 2'd1;
  logic [7:0]       pe_op_b = 8'd0;
  logic [ACC_W-1:0] pe_acc = 26'd1234567;
  logic [ACC_W-1:0] pe_sum = 26'd1234567;
  logic [ACC_W-1:0] pe_carry = '0;
  logic [ACC_W-1:0] split = 26'h2a5f3c1;
  logic [ACC_W-1:0] pe_next;

  assign pe_next   = (pe_clr ? pe_acc : '0) + contrib(pe_op_pos, pe_op_b);
  assign pe_result = {pe_sum, pe_carry};

  always @(posedge clk) begin
    pe_op_pos <= pe_encoder_position;
    pe_op_b   <= pe_operand_b;
    pe_acc    <= pe_next;
    pe_sum    <= pe_next - split;
    pe_carry  <= split;
    split     <= {split[ACC_W-2:0], split[ACC_W-1] ^ split[19] ^ split[3]};
  end

  // Reference model and compare process. Edge index `cyc` is the rising edge that
  // follows the negedge numbered `cyc`.
  initial begin
    int cyc = 0;
    bit m_open = 0;
    int m_len = 0;
    int m_need = 0;
    int m_first_edge = -100;
    int m_out_edge = -100;
    logic [ACC_W-1:0] m_sum = '0;
    logic [ACC_W-1:0] m_hold = '0;
    bit prev_acc = 0;
    logic [1:0] prev_pos = 2'd1;
    logic [7:0] prev_b = 8'd0;
    bit exp_ready;
    bit exp_valid;
    bit acc_next;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_open = 0; m_need = 0; m_hold = '0; m_sum = '0;
        m_first_edge = -100; m_out_edge = -100; prev_acc = 0;
      end
      exp_ready = m_open && (m_need > 0);
      exp_valid = m_open && (m_need == 0) && (cyc > m_out_edge);
      if (exp_valid) m_hold = m_sum;
      if (!pe_clr) clr_lows++;
      check("busy", busy, m_open);
      check("in_ready", in_ready, exp_ready);
      check("out_valid", out_valid, exp_valid);
      check("out_data", out_data, m_hold);
      check("pe_clr", pe_clr, !(cyc == m_first_edge + 2));
      check("pe_pos", pe_encoder_position, prev_acc ? prev_pos : 2'd1);
      check("pe_b", pe_operand_b, prev_acc ? prev_b : 8'd0);
      acc_next = rst_n && exp_ready && in_valid;
      if (acc_next) begin
        if (m_need == m_len) m_first_edge = cyc;
        m_sum = m_sum + contrib(in_pos, in_b);
        m_need--;
        if (m_need == 0) m_out_edge = cyc + 3;
      end
      prev_acc = acc_next; prev_pos = in_pos; prev_b = in_b;
      if (rst_n && exp_valid && out_ready) begin
        m_open = 0;
        if (exp_q.size() == 0) check("result_unexpected", 1, 0);
        else check("result", out_data, exp_q.pop_front());
      end else if (rst_n && !m_open && start) begin
        m_open = 1; m_len = int'(cfg_len); m_need = m_len; m_sum = '0;
        m_out_edge = cyc;
      end
      cyc++;
    end
  end

  // Driver tasks: inputs change 2 time units after a rising edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic start_job(input int len);
    start = 1'b1;
    cfg_len = LEN_W'(len);
    step();
    start = 1'b0;
    cfg_len = LEN_W'($urandom_range(0, 65535));
  endtask

  task automatic send_elem(input logic [1:0] p, input logic [7:0] b);
    int g = 0;
    in_valid = 1'b1; in_pos = p; in_b = b;
    while (!in_ready && g < 50) begin step(); g++; end
    if (g >= 50) check("in_ready_timeout", in_ready, 1);
    step();
    in_valid = 1'b0;
    in_pos = 2'($urandom_range(0, 3));
    in_b = 8'($urandom_range(1, 255));
  endtask

  task automatic wait_valid();
    int g = 0;
    while (!out_valid && g < 20) begin step(); g++; end
    check("out_valid_timeout", out_valid, 1);
  endtask

  task automatic wait_idle();
    int g = 0;
    while (busy && g < 20) begin step(); g++; end
    check("idle_timeout", busy, 0);
  endtask

  logic [1:0] t_pos[4] = '{2'd1, 2'd2, 2'd3, 2'd0};
  logic [7:0] t_b[4]   = '{8'd3, 8'd5, 8'hfe, 8'd7};

  task automatic job4(input int gap);
    start_job(4);
    exp_q.push_back(26'd1);
    for (int i = 0; i < 4; i++) begin
      send_elem(t_pos[i], t_b[i]);
      if (i < 3) repeat (gap) step();
    end
  endtask

  initial begin
    do_reset();
    step();
    check("reset_busy", busy, 0);
    check("reset_pe_clr", pe_clr, 1);
    check("reset_out_data", out_data, 0);

    // 1: consecutive elements, result latency and single clear pulse
    clr_lows = 0;
    job4(0);
    step(); step();
    check("t1_valid_early", out_valid, 0);
    step();
    check("t1_valid_lat", out_valid, 1);
    check("t1_data", out_data, 26'd1);
    step();
    check("t1_idle", busy, 0);
    check("t1_clr_pulses", clr_lows, 1);

    // 2: two-cycle gaps between elements
    job4(2);
    wait_valid();
    check("t2_data", out_data, 26'd1);
    step();
    wait_idle();

    // 3: back-to-back jobs, second must not see the first's accumulation
    job4(0);
    wait_valid();
    step();
    start_job(1);
    exp_q.push_back(26'd256);
    send_elem(2'd0, 8'h80);
    wait_valid();
    check("t3_data", out_data, 26'd256);
    step();
    wait_idle();

    // 4: stalled consumer, start and element offers ignored while busy
    out_ready = 1'b0;
    job4(0);
    wait_valid();
    in_valid = 1'b1; in_pos = 2'd0; in_b = 8'h7f;
    for (int i = 0; i < 5; i++) begin
      start = (i == 1);
      cfg_len = 16'd3;
      step();
      check("t4_hold_data", out_data, 26'd1);
      check("t4_busy", busy, 1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    start = 1'b1;
    cfg_len = 16'd2;
    step();
    start = 1'b0;
    check("t4_idle", busy, 0);
    check("t4_valid_low", out_valid, 0);
    check("t4_data_kept", out_data, 26'd1);
    step();

    // 5: zero-length job
    clr_lows = 0;
    start_job(0);
    exp_q.push_back(26'd0);
    check("t5_valid", out_valid, 1);
    check("t5_data", out_data, 26'd0);
    step();
    check("t5_idle", busy, 0);
    check("t5_clr_pulses", clr_lows, 0);

    // 6: reset mid-stream, then a maximum-length job
    start_job(4);
    send_elem(2'd2, 8'd100);
    send_elem(2'd1, 8'd50);
    rst_n = 1'b0;
    #1;
    check("t6_rst_busy", busy, 0);
    check("t6_rst_ready", in_ready, 0);
    check("t6_rst_pos", pe_encoder_position, 2'd1);
    check("t6_rst_b", pe_operand_b, 8'd0);
    check("t6_rst_clr", pe_clr, 1);
    check("t6_rst_valid", out_valid, 0);
    step();
    rst_n = 1'b1;
    step();
    start_job(65535);
    exp_q.push_back(26'd16776960);
    for (int i = 0; i < 65535; i++) send_elem(2'd0, 8'h80);
    wait_valid();
    check("t6_data", out_data, 26'd16776960);
    step();
    wait_idle();
    repeat (3) step();
    check("exp_q_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
